// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: address width, access size codes,
// FSM state encoding and the alignment rule.
package mem_pkg;

  localparam int MEM_AW = 10;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } lsu_state_t;

  // Size 2'b11 is not a legal access, so it is reported the same way as a misalignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_extend.sv
// Right-justified load data extension: selects the byte/half/word field and
// zero- or sign-extends it to 32 bits.
module mem_extend
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  logic fill;

  always_comb begin
    fill = 1'b0;
    dout = din;
    case (size)
      SZ_BYTE: begin
        fill = ~is_unsigned & din[7];
        dout = {{24{fill}}, din[7:0]};
      end
      SZ_HALF: begin
        fill = ~is_unsigned & din[15];
        dout = {{16{fill}}, din[15:0]};
      end
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Single-outstanding load/store unit between the pipeline and a data memory with
// a one-cycle registered read port.
module mem_lsu
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [MEM_AW-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_wena,
  output logic              mem_ba,
  output logic              mem_ha,
  output logic              mem_ua,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  lsu_state_t        state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [31:0]       ext_data;
  logic              req_bad;

  mem_extend u_extend (
    .size        (size_q),
    .is_unsigned (uns_q),
    .din         (mem_dout),
    .dout        (ext_data)
  );

  assign req_bad = is_misaligned(req_size, req_addr[1:0]);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          // Clearing here leaves stores and errors reporting zero data.
          rdata_d = 32'd0;
          err_d   = req_bad;
          state_d = req_bad ? RESP : ACCESS;
        end
      end
      ACCESS:  state_d = we_q ? RESP : CAPTURE;
      CAPTURE: begin
        rdata_d = ext_data;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Strobes decode straight from the state flop so a reset kills a write at once.
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_wena  = (state_q == ACCESS) & we_q;
  assign mem_ba    = (state_q == ACCESS) & (size_q == SZ_BYTE);
  assign mem_ha    = (state_q == ACCESS) & (size_q == SZ_HALF);
  assign mem_ua    = (state_q == ACCESS) & uns_q;
  assign mem_addr  = addr_q;
  assign mem_din   = wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a byte-addressed little-endian memory model
// whose read data is registered one edge after the address.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_wena, mem_ba, mem_ha, mem_ua;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  int checks = 0;
  int failures = 0;
  int wena_count = 0;
  logic mem_init = 1'b1;
  logic [7:0] mem [0:1023];

  mem_lsu dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_wena     (mem_wena),
    .mem_ba       (mem_ba),
    .mem_ha       (mem_ha),
    .mem_ua       (mem_ua),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'(i) ^ 8'h5A;
    end else if (mem_wena) begin
      mem[mem_addr] <= mem_din[7:0];
      if (!mem_ba) mem[mem_addr + 10'd1] <= mem_din[15:8];
      if (!mem_ba && !mem_ha) begin
        mem[mem_addr + 10'd2] <= mem_din[23:16];
        mem[mem_addr + 10'd3] <= mem_din[31:24];
      end
    end
    mem_dout <= {mem[mem_addr + 10'd3], mem[mem_addr + 10'd2],
                 mem[mem_addr + 10'd1], mem[mem_addr]};
    if (mem_wena) wena_count <= wena_count + 1;
  end

  // Full request/response handshake; returns observed data and accept-to-valid latency.
  task automatic transact(input logic we, input logic [1:0] size, input logic uns,
                          input logic [9:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
    int guard;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wdata;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    $display("txn we=%0d size=%0d uns=%0d addr=0x%03h wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d",
             we, size, uns, addr, wdata, rdata, err, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 10'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mem_init = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_handshake ready=%b valid=%b required ready=1 valid=0", req_ready, rsp_valid);
    end
    checks++;
    if (rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_rsp rdata=0x%08h err=%b required 0/0", rsp_rdata, rsp_err);
    end
    checks++;
    if ({mem_wena, mem_ba, mem_ha, mem_ua} !== 4'b0000 || mem_addr !== 10'd0 || mem_din !== 32'd0) begin
      failures++;
      $display("FAIL reset_mem wena/ba/ha/ua=%b addr=0x%03h din=0x%08h required 0000/0/0",
               {mem_wena, mem_ba, mem_ha, mem_ua}, mem_addr, mem_din);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load_word();
    logic [31:0] rd; logic er; int lat;
    transact(1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF, rd, er, lat);
    checks++;
    if (rd !== 32'd0 || er !== 1'b0 || lat !== 2) begin
      failures++;
      $display("FAIL store_word rdata=0x%08h err=%b lat=%0d required 0x00000000/0/2", rd, er, lat);
    end
    transact(1'b0, 2'b10, 1'b1, 10'h010, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 3) begin
      failures++;
      $display("FAIL load_word rdata=0x%08h err=%b lat=%0d required 0xdeadbeef/0/3", rd, er, lat);
    end
  endtask

  task automatic test_load_byte();
    logic [31:0] rd; logic er; int lat;
    transact(1'b0, 2'b00, 1'b0, 10'h013, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hFFFFFFDE || er !== 1'b0 || lat !== 3) begin
      failures++;
      $display("FAIL load_byte_signed rdata=0x%08h err=%b lat=%0d required 0xffffffde/0/3", rd, er, lat);
    end
    transact(1'b0, 2'b00, 1'b1, 10'h013, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h000000DE || er !== 1'b0) begin
      failures++;
      $display("FAIL load_byte_unsigned rdata=0x%08h err=%b required 0x000000de/0", rd, er);
    end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic er; int lat;
    transact(1'b1, 2'b01, 1'b0, 10'h020, 32'hABCD8001, rd, er, lat);
    checks++;
    if (rd !== 32'd0 || er !== 1'b0 || lat !== 2) begin
      failures++;
      $display("FAIL store_half rdata=0x%08h err=%b lat=%0d required 0x00000000/0/2", rd, er, lat);
    end
    transact(1'b0, 2'b01, 1'b0, 10'h020, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hFFFF8001 || er !== 1'b0) begin
      failures++;
      $display("FAIL load_half_signed rdata=0x%08h err=%b required 0xffff8001/0", rd, er);
    end
    transact(1'b0, 2'b01, 1'b1, 10'h020, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h00008001 || er !== 1'b0) begin
      failures++;
      $display("FAIL load_half_unsigned rdata=0x%08h err=%b required 0x00008001/0", rd, er);
    end
    transact(1'b0, 2'b01, 1'b1, 10'h022, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h00007978) begin
      failures++;
      $display("FAIL half_neighbours rdata=0x%08h required 0x00007978", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat; int base;
    logic [9:0] addrs [4];
    logic [1:0] sizes [4];
    logic       wes   [4];
    addrs = '{10'h011, 10'h021, 10'h000, 10'h012};
    sizes = '{2'b10,   2'b01,   2'b11,   2'b10};
    wes   = '{1'b0,    1'b0,    1'b0,    1'b1};
    base = wena_count;
    for (int i = 0; i < 4; i++) begin
      transact(wes[i], sizes[i], 1'b0, addrs[i], 32'h55AA55AA, rd, er, lat);
      checks++;
      if (rd !== 32'd0 || er !== 1'b1 || lat !== 1) begin
        failures++;
        $display("FAIL error_req%0d rdata=0x%08h err=%b lat=%0d required 0x00000000/1/1", i, rd, er, lat);
      end
    end
    checks++;
    if (wena_count !== base) begin
      failures++;
      $display("FAIL error_no_write wena_pulses=%0d required 0", wena_count - base);
    end
  endtask

  task automatic test_access_signals();
    logic [31:0] rd; logic er; int lat;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b1;
    req_addr = 10'h031; req_wdata = 32'h000000A5;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 10'h3FF; req_wdata = 32'hFFFFFFFF;
    checks++;
    if ({mem_wena, mem_ba, mem_ha, mem_ua} !== 4'b1101 || mem_addr !== 10'h031 || mem_din !== 32'h000000A5) begin
      failures++;
      $display("FAIL access_strobes wena/ba/ha/ua=%b addr=0x%03h din=0x%08h required 1101/0x031/0x000000a5",
               {mem_wena, mem_ba, mem_ha, mem_ua}, mem_addr, mem_din);
    end
    @(posedge clk); #1;
    checks++;
    if (mem_wena !== 1'b0 || rsp_valid !== 1'b1 || mem_addr !== 10'h031) begin
      failures++;
      $display("FAIL access_after wena=%b valid=%b addr=0x%03h required 0/1/0x031", mem_wena, rsp_valid, mem_addr);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    $display("txn we=1 size=0 uns=1 addr=0x031 wdata=0x000000a5 (strobe check)");
    transact(1'b0, 2'b00, 1'b1, 10'h031, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h000000A5) begin
      failures++;
      $display("FAIL byte_store_readback rdata=0x%08h required 0x000000a5", rd);
    end
    transact(1'b0, 2'b00, 1'b1, 10'h032, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h00000068) begin
      failures++;
      $display("FAIL byte_store_neighbour rdata=0x%08h required 0x00000068", rd);
    end
  endtask

  task automatic test_backpressure();
    int guard; int base;
    base = wena_count;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b1;
    req_addr = 10'h010; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    guard = 0;
    while (!rsp_valid && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    for (int c = 0; c < 5; c++) begin
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 10'h010; req_wdata = 32'h11111111;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d valid=%b rdata=0x%08h req_ready=%b required 1/0xdeadbeef/0",
                 c, rsp_valid, rsp_rdata, req_ready);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL consume_cycle req_ready=%b valid=%b required 0/1", req_ready, rsp_valid);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || wena_count !== base) begin
      failures++;
      $display("FAIL after_consume valid=%b req_ready=%b wena_pulses=%0d required 0/1/0",
               rsp_valid, req_ready, wena_count - base);
    end
    $display("txn we=0 size=2 uns=1 addr=0x010 held 5 cycles rdata=0x%08h", rsp_rdata);
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er; int lat; int seen;
    transact(1'b1, 2'b10, 1'b0, 10'h040, 32'hCAFEF00D, rd, er, lat);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 10'h040; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (mem_wena !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre_wena wena=%b required 1", mem_wena);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (mem_wena !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_addr !== 10'd0) begin
      failures++;
      $display("FAIL abort_async wena=%b valid=%b req_ready=%b addr=0x%03h required 0/0/1/0x000",
               mem_wena, rsp_valid, req_ready, mem_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL abort_no_rsp rsp_valid_cycles=%0d required 0", seen);
    end
    $display("txn we=1 size=2 addr=0x040 wdata=0x12345678 aborted by reset");
    transact(1'b0, 2'b10, 1'b1, 10'h040, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0 || lat !== 3) begin
      failures++;
      $display("FAIL abort_readback rdata=0x%08h err=%b lat=%0d required 0xcafef00d/0/3", rd, er, lat);
    end
  endtask

  initial begin
    test_reset();
    test_store_load_word();
    test_load_byte();
    test_half();
    test_errors();
    test_access_signals();
    test_backpressure();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-high; ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock shared with the data memory.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  pipeline presents an access request.
REQ-005 req_ready  output  1  block accepts a request; transfer occurs on req_valid & req_ready at a rising edge.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 req_addr  input  10  byte address.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 rsp_valid  output  1  response available; held until rsp_ready.
REQ-012 rsp_ready  input  1  pipeline consumes the response.
REQ-013 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 rsp_err  output  1  misaligned or illegal-size request.
REQ-015 mem_wena, mem_ba, mem_ha, mem_ua  output  1 each  memory write-enable, byte, half and unsigned qualifiers.
REQ-016 mem_addr  output  10  memory byte address.
REQ-017 mem_din  output  32  memory write data.
REQ-018 mem_dout  input  32  memory read data, little-endian, registered inside memory one edge after mem_addr.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS, CAPTURE, RESP; req_ready = 1 only in IDLE.
REQ-020 On accept in IDLE, the block SHALL latch we, size, unsigned, addr and wdata.
REQ-021 Misaligned means half with addr[0]=1, word with addr[1:0]!=00, or size=11; such a request SHALL go IDLE->RESP with rsp_err=1 and no memory access.
REQ-022 Aligned request SHALL go IDLE->ACCESS; ACCESS lasts exactly one cycle.
REQ-023 In ACCESS, mem_wena SHALL equal latched we; mem_ba=(size==00), mem_ha=(size==01), mem_ua=latched unsigned.
REQ-024 mem_addr and mem_din SHALL drive the latched addr and wdata in every state.
REQ-025 mem_wena SHALL be 0 in every state other than ACCESS.
REQ-026 Store: ACCESS->RESP; rsp_rdata=0, rsp_err=0.
REQ-027 Load: ACCESS->CAPTURE; in CAPTURE, mem_dout is valid and SHALL be extended and registered into rsp_rdata; CAPTURE->RESP.
REQ-028 Extension SHALL be: byte = mem_dout[7:0], half = mem_dout[15:0], word = mem_dout; upper bits are zero if unsigned, else replicate the MSB of the field.
REQ-029 Latency, counted from the accept edge N, to the first rsp_valid cycle SHALL be: error N+1, store N+2, load N+3.
REQ-030 RESP SHALL hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready=1, then go to IDLE; rsp_valid=0 in all other states.
REQ-031 A new request SHALL not be accepted in the cycle a response is consumed; there is one bubble between responses.
REQ-032 req_* inputs SHALL be ignored outside IDLE.

Reset
REQ-033 rst SHALL asynchronously force state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_wena=0, mem_ba=0, mem_ha=0, mem_ua=0, mem_addr=0, mem_din=0.
REQ-034 Reset mid-operation SHALL abort the access, with no write and no response issued afterwards; if asserted during ACCESS of a store, mem_wena SHALL drop immediately.

Structure
REQ-035 Shared package mem_pkg SHALL hold MEM_AW=10, size encodings SZ_BYTE/SZ_HALF/SZ_WORD and the lsu_state_t enum.
REQ-036 The extension logic SHALL be the sub-module mem_extend (size, unsigned, 32-bit in -> 32-bit out, combinational).

Verification
REQ-037 Store word 0xDEADBEEF @0x010, then load word unsigned @0x010 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 3 cycles after the load accept.
REQ-038 Load byte signed @0x013 after REQ-037 -> 0xFFFFFFDE; load byte unsigned @0x013 -> 0x000000DE.
REQ-039 Store half 0x8001 @0x020, load half signed -> 0xFFFF8001; load half unsigned -> 0x00008001; bytes 0x022/0x023 unchanged.
REQ-040 Load word @0x011, half @0x021 and size=11 @0x000 -> rsp_err=1, rsp_rdata=0, mem_wena never asserted, rsp_valid 1 cycle after accept.
REQ-041 Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable; req_ready=0 throughout.
REQ-042 Assert rst during ACCESS of a store word 0x12345678 @0x040 -> mem_wena drops at once, no response; a subsequent load @0x040 returns the prior contents.
